// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared widths, reset default and FSM state type for the
// program-counter / jump controller.
//   PC_W             fetch address width (word-addressed)
//   OFF_W            jump offset width (two's complement)
//   RESET_PC_DEFAULT default PC loaded on reset
//   pc_state_e       controller state encoding
package pc_ctrl_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned OFF_W = 12;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFlush,
    StHalt
  } pc_state_e;

endpackage

// File: rtl/pc_target_adder.sv
// pc_target_adder: combinational jump target computation.
// Sign-extends the jump offset to PC width and adds it to the jump
// instruction address; the sum wraps modulo 2^PC_W.
// Ports:
//   i_jmp_pc  [PC_W-1:0]  address of the jump instruction
//   i_jmp_off [OFF_W-1:0] two's-complement offset
//   o_target  [PC_W-1:0]  jump target address
module pc_target_adder
  import pc_ctrl_pkg::*;
(
  input  logic [PC_W-1:0]  i_jmp_pc,
  input  logic [OFF_W-1:0] i_jmp_off,
  output logic [PC_W-1:0]  o_target
);

  logic [PC_W-1:0] w_off_sext;

  assign w_off_sext = {{(PC_W - OFF_W){i_jmp_off[OFF_W-1]}}, i_jmp_off};
  assign o_target   = i_jmp_pc + w_off_sext;

endmodule

// File: rtl/pc_jump_ctrl.sv
// pc_jump_ctrl: instruction fetch PC sequencer with jump redirect.
// States: IDLE (after reset), FETCH (issuing requests), FLUSH (one-cycle
// redirect bubble, flush asserted), HALT (sticky until reset).
// Priority: rst > jmp_valid > halt > stall > sequential increment.
// Optional build macro PC_JUMP_LINK_EN adds a link-register write port.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   fetch_req / fetch_ack fetch request (FETCH only) / memory accept
//   pc        [15:0]     current fetch address
//   stall                hold pc
//   jmp_valid/jmp_pc/jmp_off  resolved jump from decode
//   halt                 stop fetching until reset
//   flush                registered, high for the single FLUSH cycle
//   jmp_link/link_we/link_addr (PC_JUMP_LINK_EN only) link write-back
module pc_jump_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic [PC_W-1:0]  pc,
  input  logic             stall,
  input  logic             jmp_valid,
  input  logic [PC_W-1:0]  jmp_pc,
  input  logic [OFF_W-1:0] jmp_off,
  input  logic             halt,
`ifdef PC_JUMP_LINK_EN
  input  logic             jmp_link,
  output logic             link_we,
  output logic [PC_W-1:0]  link_addr,
`endif
  output logic             flush
);

  pc_state_e       r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic            r_flush, w_flush_next;
  logic [PC_W-1:0] w_target;
  logic            w_jump_take;

  pc_target_adder u_target_adder (
    .i_jmp_pc  (jmp_pc),
    .i_jmp_off (jmp_off),
    .o_target  (w_target)
  );

  // A jump is only accepted from IDLE or FETCH; FLUSH and HALT ignore it.
  assign w_jump_take = jmp_valid && ((r_state == StIdle) || (r_state == StFetch));

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_flush_next = 1'b0;
    case (r_state)
      StIdle, StFetch: begin
        if (w_jump_take) begin
          // Redirect drops any unacknowledged request; flush kills its response.
          w_pc_next    = w_target;
          w_flush_next = 1'b1;
          w_state_next = StFlush;
        end else if (halt) begin
          w_state_next = StHalt;
        end else if (r_state == StIdle) begin
          w_state_next = StFetch;
        end else if (fetch_ack && !stall) begin
          w_pc_next = r_pc + 16'd1;
        end
      end
      StFlush: begin
        w_state_next = StFetch;
      end
      StHalt: begin
        w_state_next = StHalt;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_flush <= w_flush_next;
    end
  end

  assign fetch_req = (r_state == StFetch);
  assign pc        = r_pc;
  assign flush     = r_flush;

`ifdef PC_JUMP_LINK_EN
  logic            r_link_we;
  logic [PC_W-1:0] r_link_addr;
  logic            w_link_take;

  assign w_link_take = w_jump_take && jmp_link;

  // Link write pulses in the same cycle flush is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_link_we   <= 1'b0;
      r_link_addr <= '0;
    end else begin
      r_link_we <= w_link_take;
      if (w_link_take) begin
        r_link_addr <= jmp_pc + 16'd1;
      end
    end
  end

  assign link_we   = r_link_we;
  assign link_addr = r_link_addr;
`endif

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Self-checking bench for pc_jump_ctrl: directed vectors followed by random
// traffic; every cycle's expected outputs come from a behavioural model and
// are queued for a monitor that compares them against the DUT.
module tb_pc_jump_ctrl;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst, fetch_ack, stall, jmp_valid, halt;
  logic [15:0] jmp_pc;
  logic [11:0] jmp_off;
  logic        fetch_req, flush;
  logic [15:0] pc;
`ifdef PC_JUMP_LINK_EN
  logic        jmp_link, link_we;
  logic [15:0] link_addr;
`endif

  always #5 clk = ~clk;

  pc_jump_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .pc        (pc),
    .stall     (stall),
    .jmp_valid (jmp_valid),
    .jmp_pc    (jmp_pc),
    .jmp_off   (jmp_off),
    .halt      (halt),
`ifdef PC_JUMP_LINK_EN
    .jmp_link  (jmp_link),
    .link_we   (link_we),
    .link_addr (link_addr),
`endif
    .flush     (flush)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic        fetch_req;
    logic        flush;
    logic        link_we;
    logic [15:0] link_addr;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: a handful of flags plus the PC as a plain integer.
  bit m_fresh, m_fetching, m_flushing, m_halted, m_link_we;
  int m_pc = 0, m_link_addr = 0;

  function automatic int jump_target(input int base, input int off12);
    int soff;
    soff = (off12 >= 2048) ? off12 - 4096 : off12;
    return (base + soff + 65536) % 65536;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_advance(input bit r, a, s, j, input int jp, jo, input bit h, lk);
    m_link_we = 1'b0;
    if (r) begin
      m_pc = RST_PC; m_fresh = 1; m_fetching = 0; m_flushing = 0; m_halted = 0;
      m_link_addr = 0;
    end else if (m_flushing) begin
      m_flushing = 0; m_fetching = 1;
    end else if (m_halted) begin
      // stays halted, jumps ignored
    end else if (j) begin
      m_pc = jump_target(jp, jo);
      m_flushing = 1; m_fetching = 0; m_fresh = 0;
`ifdef PC_JUMP_LINK_EN
      if (lk) begin
        m_link_we = 1'b1;
        m_link_addr = (jp + 1) % 65536;
      end
`endif
    end else if (h) begin
      m_halted = 1; m_fetching = 0; m_fresh = 0;
    end else if (m_fresh) begin
      m_fresh = 0; m_fetching = 1;
    end else if (a && !s) begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  task automatic step(input bit r, a, s, j, input int jp, jo, input bit h, lk);
    obs_t e;
    @(negedge clk);
    rst = r; fetch_ack = a; stall = s; jmp_valid = j; halt = h;
    jmp_pc = 16'(jp); jmp_off = 12'(jo);
`ifdef PC_JUMP_LINK_EN
    jmp_link = lk;
`endif
    model_advance(r, a, s, j, jp, jo, h, lk);
    e.pc = 16'(m_pc); e.fetch_req = m_fetching; e.flush = m_flushing;
    e.link_we = m_link_we; e.link_addr = 16'(m_link_addr);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one observation per clock while expectations are queued.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", 32'(pc), 32'(e.pc));
        chk("sb_fetch_req", 32'(fetch_req), 32'(e.fetch_req));
        chk("sb_flush", 32'(flush), 32'(e.flush));
`ifdef PC_JUMP_LINK_EN
        chk("sb_link_we", 32'(link_we), 32'(e.link_we));
        chk("sb_link_addr", 32'(link_addr), 32'(e.link_addr));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; fetch_ack = 0; stall = 0; jmp_valid = 0; halt = 0; jmp_pc = 0; jmp_off = 0;
`ifdef PC_JUMP_LINK_EN
    jmp_link = 0;
`endif
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", 32'(pc), 32'h0100);
    chk("reset_fetch_req", 32'(fetch_req), 0);
    chk("reset_flush", 32'(flush), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_to_fetch", 32'(fetch_req), 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("seq_inc", 32'(pc), 32'h0101);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("no_ack_hold", 32'(pc), 32'h0101);

    // Backward jump
    step(0, 0, 0, 1, 'h0010, 'hFFE, 0, 0);
    chk("jmp_back_pc", 32'(pc), 32'h000E);
    chk("jmp_back_flush", 32'(flush), 1);
    chk("jmp_back_no_req", 32'(fetch_req), 0);
    step(0, 0, 0, 1, 'h5555, 'h001, 0, 0);  // jump during FLUSH is ignored
    chk("flush_one_cycle", 32'(flush), 0);
    chk("flush_resume_req", 32'(fetch_req), 1);
    chk("flush_ignores_jmp", 32'(pc), 32'h000E);

    // Forward jump with wrap
    step(0, 1, 0, 1, 'hFFF0, 'h7FF, 0, 0);
    chk("jmp_wrap_pc", 32'(pc), 32'h07EF);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // PC wrap at 16'hFFFF, stall hold
    step(0, 0, 0, 1, 'h0000, 'hFFF, 0, 0);
    chk("jmp_to_ffff", 32'(pc), 32'hFFFF);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("stall_hold", 32'(pc), 32'hFFFF);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("inc_wrap", 32'(pc), 32'h0000);

    // Jump beats halt and stall
    step(0, 1, 1, 1, 'h1234, 'h010, 1, 0);
    chk("jmp_over_halt_pc", 32'(pc), 32'h1244);
    chk("jmp_over_halt_flush", 32'(flush), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("jmp_over_halt_fetch", 32'(fetch_req), 1);

    // Halt: pc held, jumps ignored, only reset leaves
    step(0, 1, 0, 0, 0, 0, 1, 0);
    chk("halt_no_req", 32'(fetch_req), 0);
    chk("halt_pc_hold", 32'(pc), 32'h1244);
    step(0, 1, 0, 1, 'h0300, 'h001, 0, 0);
    chk("halt_ignores_jmp", 32'(pc), 32'h1244);

    // Reset during FLUSH
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 'h2000, 'h001, 0, 0);
    chk("pre_rst_flush", 32'(flush), 1);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_in_flush_pc", 32'(pc), 32'h0100);
    chk("rst_in_flush_flush", 32'(flush), 0);
    chk("rst_in_flush_req", 32'(fetch_req), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_then_fetch", 32'(fetch_req), 1);

`ifdef PC_JUMP_LINK_EN
    step(0, 0, 0, 1, 'h0042, 'h005, 0, 1);
    chk("link_we", 32'(link_we), 1);
    chk("link_addr", 32'(link_addr), 32'h0043);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("link_we_pulse", 32'(link_we), 0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 4095)),
           $urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
